// File: rtl/peridot_i2c_serial2.sv
// peridot_i2c_serial2 - I2C slave byte engine for PERIDOT peripherals.
//
// The raw pad inputs are synchronised and glitch filtered. The engine detects
// START/STOP, decodes a 7-bit address with automatic ACK, tracks the transfer
// direction, and hands data bytes to a register/bridge controller. SDA updates
// are delayed by HOLD_CYCLES after the filtered SCL fall. SCL is optionally
// stretched while the user decides the write ACK or supplies transmit data.
//
// Ports:
//   clock_sig, reset_sig     clock (posedge) and async active-high reset
//   i2c_scl_i / i2c_scl_o    raw SCL input / SCL drive (0 = pull low)
//   i2c_sda_i / i2c_sda_o    raw SDA input / SDA drive (0 = pull low)
//   condi_start, condi_stop  1-clock pulses on START (incl. repeated) / STOP
//   addr_match, rw_dir       address matched pulse / last matched R/W bit
//   busy                     engine is not in IDLE or IGNORE
//   done_byte                received data byte valid on recieve_bytedata
//   ackwaitrequest,
//   send_ackdata             user ACK handshake for write bytes
//   done_ack                 pulse at the SCL fall of the 9th clock
//   send_bytedata, send_bytedatavalid, send_byteload
//                            transmit byte handshake for read bytes
//   recieve_bytedata         last received byte (address bytes included)
//   recieve_ackdata          master ACK of the last transmitted byte
//
// state    | meaning
// IDLE     | bus free, lines released
// ADDR     | shifting in the address byte
// ADDR_ACK | driving the automatic address ACK
// WR_DATA  | shifting in a write data byte
// WR_ACK   | user ACK/NACK phase (may stretch SCL)
// LOAD     | fetching the next transmit byte (may stretch SCL)
// RD_DATA  | shifting out a read data byte
// RD_ACK   | sampling the master ACK
// IGNORE   | not addressed / NACKed, wait for START or STOP

module peridot_i2c_serial2 #(
  parameter int unsigned FILTER_STAGES  = 3,
  parameter logic [6:0]  SLAVE_ADDRESS  = 7'h50,
  parameter logic [6:0]  ADDRESS_MASK   = 7'h7F,
  parameter bit          ADDR_ENABLE    = 1'b1,
  parameter bit          STRETCH_ENABLE = 1'b1,
  parameter int unsigned HOLD_CYCLES    = 2
) (
  input  logic       clock_sig,
  input  logic       reset_sig,
  input  logic       i2c_scl_i,
  output logic       i2c_scl_o,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       condi_start,
  output logic       condi_stop,
  output logic       addr_match,
  output logic       rw_dir,
  output logic       busy,
  output logic       done_byte,
  input  logic       ackwaitrequest,
  input  logic       send_ackdata,
  output logic       done_ack,
  input  logic [7:0] send_bytedata,
  input  logic       send_bytedatavalid,
  output logic       send_byteload,
  output logic [7:0] recieve_bytedata,
  output logic       recieve_ackdata
);

  localparam logic [3:0] FILT_LOAD = 4'(FILTER_STAGES - 1);
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WR_DATA, ST_WR_ACK,
    ST_LOAD, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic        scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [3:0]  scl_fcnt_q, scl_fcnt_d, sda_fcnt_q, sda_fcnt_d;
  logic        scl_dly_q, scl_dly_d, sda_dly_q, sda_dly_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d, tx_q, tx_d;
  logic        ack_given_q, ack_given_d, ack_decided_q, ack_decided_d;
  logic        hold_pend_q, hold_pend_d, hold_val_q, hold_val_d;
  logic        hold_rel_q, hold_rel_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        scl_o_q, scl_o_d, sda_o_q, sda_o_d;
  logic        rw_q, rw_d, busy_q, busy_d;
  logic [7:0]  rbyte_q, rbyte_d;
  logic        rack_q, rack_d;
  logic        start_p_q, start_p_d, stop_p_q, stop_p_d, match_p_q, match_p_d;
  logic        dbyte_p_q, dbyte_p_d, dack_p_q, dack_p_d, load_p_q, load_p_d;

  logic scl_rise, scl_fall, cond_start, cond_stop, addr_hit;
  logic req, req_val, req_rel, ld_go, ld_msb;

  always_comb begin
    // input synchroniser and filter: level flips after FILTER_STAGES
    // consecutive samples disagree with it
    scl_sync_d = {scl_sync_q[0], i2c_scl_i};
    sda_sync_d = {sda_sync_q[0], i2c_sda_i};
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    scl_fcnt_d = scl_fcnt_q;
    sda_fcnt_d = sda_fcnt_q;
    if (scl_sync_q[1] == scl_f_q) scl_fcnt_d = FILT_LOAD;
    else if (scl_fcnt_q == 4'd0) begin
      scl_f_d    = scl_sync_q[1];
      scl_fcnt_d = FILT_LOAD;
    end else scl_fcnt_d = scl_fcnt_q - 4'd1;
    if (sda_sync_q[1] == sda_f_q) sda_fcnt_d = FILT_LOAD;
    else if (sda_fcnt_q == 4'd0) begin
      sda_f_d    = sda_sync_q[1];
      sda_fcnt_d = FILT_LOAD;
    end else sda_fcnt_d = sda_fcnt_q - 4'd1;
    scl_dly_d = scl_f_q;
    sda_dly_d = sda_f_q;

    scl_rise   = scl_f_q & ~scl_dly_q;
    scl_fall   = ~scl_f_q & scl_dly_q;
    cond_start = scl_f_q & scl_dly_q & sda_dly_q & ~sda_f_q;
    cond_stop  = scl_f_q & scl_dly_q & ~sda_dly_q & sda_f_q;
    addr_hit   = (((rx_q[7:1] ^ SLAVE_ADDRESS) & ADDRESS_MASK) == 7'h00);

    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    ack_given_d   = ack_given_q;
    ack_decided_d = ack_decided_q;
    hold_pend_d   = hold_pend_q;
    hold_val_d    = hold_val_q;
    hold_rel_d    = hold_rel_q;
    hold_cnt_d    = hold_cnt_q;
    scl_o_d       = scl_o_q;
    sda_o_d       = sda_o_q;
    rw_d          = rw_q;
    rbyte_d       = rbyte_q;
    rack_d        = rack_q;
    start_p_d     = 1'b0;
    stop_p_d      = 1'b0;
    match_p_d     = 1'b0;
    dbyte_p_d     = 1'b0;
    dack_p_d      = 1'b0;
    load_p_d      = 1'b0;
    req           = 1'b0;
    req_val       = 1'b1;
    req_rel       = 1'b0;
    ld_go         = 1'b0;
    ld_msb        = 1'b1;

    // delayed SDA update; optionally releases SCL once the data is set up
    if (hold_pend_q) begin
      if (hold_cnt_q == 4'd0) begin
        sda_o_d     = hold_val_q;
        hold_pend_d = 1'b0;
        if (hold_rel_q) scl_o_d = 1'b1;
      end else hold_cnt_d = hold_cnt_q - 4'd1;
    end

    if (cond_start) begin
      start_p_d   = 1'b1;
      hold_pend_d = 1'b0;
      sda_o_d     = 1'b1;
      scl_o_d     = 1'b1;
      bit_cnt_d   = 4'd0;
      if (ADDR_ENABLE) state_d = ST_ADDR;
      else begin
        state_d = ST_WR_DATA;
        rw_d    = 1'b0;
      end
    end else if (cond_stop) begin
      stop_p_d    = 1'b1;
      hold_pend_d = 1'b0;
      sda_o_d     = 1'b1;
      scl_o_d     = 1'b1;
      bit_cnt_d   = 4'd0;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            rbyte_d   = rx_q;
            bit_cnt_d = 4'd0;
            if (addr_hit) begin
              match_p_d = 1'b1;
              rw_d      = rx_q[0];
              req       = 1'b1;
              req_val   = 1'b0;
              state_d   = ST_ADDR_ACK;
            end else state_d = ST_IGNORE;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_rise) bit_cnt_d = 4'd1;
          else if (scl_fall && bit_cnt_q != 4'd0) begin
            dack_p_d  = 1'b1;
            bit_cnt_d = 4'd0;
            req       = 1'b1;
            state_d   = rw_q ? ST_LOAD : ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            dbyte_p_d = 1'b1;
            rbyte_d   = rx_q;
            bit_cnt_d = 4'd0;
            state_d   = ST_WR_ACK;
            if (STRETCH_ENABLE) begin
              scl_o_d       = 1'b0;
              ack_decided_d = 1'b0;
            end else begin
              ack_decided_d = 1'b1;
              ack_given_d   = send_ackdata;
              req           = 1'b1;
              req_val       = ~send_ackdata;
            end
          end
        end
        ST_WR_ACK: begin
          if (!ack_decided_q) begin
            if (!ackwaitrequest) begin
              ack_decided_d = 1'b1;
              ack_given_d   = send_ackdata;
              req           = 1'b1;
              req_val       = ~send_ackdata;
              req_rel       = 1'b1;
            end
          end else if (scl_rise) bit_cnt_d = 4'd1;
          else if (scl_fall && bit_cnt_q != 4'd0) begin
            dack_p_d  = 1'b1;
            bit_cnt_d = 4'd0;
            req       = 1'b1;
            state_d   = ack_given_q ? ST_WR_DATA : ST_IGNORE;
          end
        end
        ST_LOAD: begin
          if (send_bytedatavalid) begin
            load_p_d = 1'b1;
            tx_d     = {send_bytedata[6:0], 1'b1};
            ld_msb   = send_bytedata[7];
            ld_go    = 1'b1;
          end else if (!STRETCH_ENABLE) begin
            tx_d  = 8'hFF;
            ld_go = 1'b1;
          end else scl_o_d = 1'b0;
          if (ld_go) begin
            state_d   = ST_RD_DATA;
            bit_cnt_d = 4'd0;
            // reuse a still-running hold from the ACK fall so the first bit
            // keeps its timing relative to that fall
            if (hold_pend_q && hold_cnt_q != 4'd0) begin
              hold_val_d = ld_msb;
              hold_rel_d = hold_rel_q | ~scl_o_q;
            end else if (!scl_o_q) begin
              req     = 1'b1;
              req_val = ld_msb;
              req_rel = 1'b1;
            end else sda_o_d = ld_msb;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            req       = 1'b1;
            state_d   = ST_RD_ACK;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            tx_d    = {tx_q[6:0], 1'b1};
            req     = 1'b1;
            req_val = tx_q[7];
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            rack_d    = ~sda_f_q;
            bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            dack_p_d  = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = rack_q ? ST_LOAD : ST_IGNORE;
          end
        end
        default: ;
      endcase
    end

    if (req) begin
      if (HOLD_CYCLES == 0) begin
        sda_o_d     = req_val;
        hold_pend_d = 1'b0;
        if (req_rel) scl_o_d = 1'b1;
      end else begin
        hold_pend_d = 1'b1;
        hold_cnt_d  = HOLD_LOAD;
        hold_val_d  = req_val;
        hold_rel_d  = req_rel;
      end
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_IGNORE);
  end

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q       <= ST_IDLE;
      scl_sync_q    <= 2'b11;
      sda_sync_q    <= 2'b11;
      scl_f_q       <= 1'b1;
      sda_f_q       <= 1'b1;
      scl_fcnt_q    <= FILT_LOAD;
      sda_fcnt_q    <= FILT_LOAD;
      scl_dly_q     <= 1'b1;
      sda_dly_q     <= 1'b1;
      bit_cnt_q     <= 4'd0;
      rx_q          <= 8'h00;
      tx_q          <= 8'hFF;
      ack_given_q   <= 1'b0;
      ack_decided_q <= 1'b0;
      hold_pend_q   <= 1'b0;
      hold_val_q    <= 1'b1;
      hold_rel_q    <= 1'b0;
      hold_cnt_q    <= 4'd0;
      scl_o_q       <= 1'b1;
      sda_o_q       <= 1'b1;
      rw_q          <= 1'b0;
      busy_q        <= 1'b0;
      rbyte_q       <= 8'h00;
      rack_q        <= 1'b0;
      start_p_q     <= 1'b0;
      stop_p_q      <= 1'b0;
      match_p_q     <= 1'b0;
      dbyte_p_q     <= 1'b0;
      dack_p_q      <= 1'b0;
      load_p_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      scl_sync_q    <= scl_sync_d;
      sda_sync_q    <= sda_sync_d;
      scl_f_q       <= scl_f_d;
      sda_f_q       <= sda_f_d;
      scl_fcnt_q    <= scl_fcnt_d;
      sda_fcnt_q    <= sda_fcnt_d;
      scl_dly_q     <= scl_dly_d;
      sda_dly_q     <= sda_dly_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      ack_given_q   <= ack_given_d;
      ack_decided_q <= ack_decided_d;
      hold_pend_q   <= hold_pend_d;
      hold_val_q    <= hold_val_d;
      hold_rel_q    <= hold_rel_d;
      hold_cnt_q    <= hold_cnt_d;
      scl_o_q       <= scl_o_d;
      sda_o_q       <= sda_o_d;
      rw_q          <= rw_d;
      busy_q        <= busy_d;
      rbyte_q       <= rbyte_d;
      rack_q        <= rack_d;
      start_p_q     <= start_p_d;
      stop_p_q      <= stop_p_d;
      match_p_q     <= match_p_d;
      dbyte_p_q     <= dbyte_p_d;
      dack_p_q      <= dack_p_d;
      load_p_q      <= load_p_d;
    end
  end

  assign i2c_scl_o        = scl_o_q;
  assign i2c_sda_o        = sda_o_q;
  assign condi_start      = start_p_q;
  assign condi_stop       = stop_p_q;
  assign addr_match       = match_p_q;
  assign rw_dir           = rw_q;
  assign busy             = busy_q;
  assign done_byte        = dbyte_p_q;
  assign done_ack         = dack_p_q;
  assign send_byteload    = load_p_q;
  assign recieve_bytedata = rbyte_q;
  assign recieve_ackdata  = rack_q;

endmodule
